// File: rtl/rr_mux_pkg.sv
// Shared channel-index types for the 4-way round-robin mux and its demux4 counterpart.
package rr_mux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;
endpackage

// File: rtl/rr_arb4.sv
// Rotating-priority 4-way arbiter: owns the priority pointer and the one-hot grant.
module rr_arb4
    import rr_mux_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req,
    input  logic                advance,
    input  ch_sel_t             adv_idx,
    output logic [NUM_CH-1:0]   grant
);
    ch_sel_t           ptr;
    logic [NUM_CH-1:0] rot;
    logic              found;

    // Rotate requests so the pointer's channel sits at bit 0, then take the lowest set bit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        rot   = NUM_CH'({req, req} >> ptr);
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && rot[j]) begin
                found                   = 1'b1;
                grant[ptr + ch_sel_t'(j)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= adv_idx + ch_sel_t'(1);
        end
    end
endmodule

// File: rtl/rr_mux4.sv
// Four valid/ready sources merged round-robin into one registered stream tagged with source index.
module rr_mux4
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in0,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    input  logic [WIDTH-1:0]  in3,
    input  logic [3:0]        in_valid,
    output logic [3:0]        in_ready,
    output logic [WIDTH-1:0]  out,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    input  logic              out_ready
);
    logic              load;
    logic              xfer;
    logic [NUM_CH-1:0] grant;
    ch_sel_t           grant_idx;
    logic [WIDTH-1:0]  grant_data;

    assign load     = !out_valid || out_ready;
    assign xfer     = load && (|grant);
    assign in_ready = {NUM_CH{load}} & grant;

    rr_arb4 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .advance (xfer),
        .adv_idx (grant_idx),
        .grant   (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) grant_idx = ch_sel_t'(i);
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    grant_data = in0;
            2'd1:    grant_data = in1;
            2'd2:    grant_data = in2;
            default: grant_data = in3;
        endcase
    end

    // Empty cycle with a free register drops out_valid but keeps the last word and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            if (xfer) begin
                out       <= grant_data;
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/rr_mux4.md
Name: rr_mux4

Overview:
- 4-channel round-robin multiplexer with valid/ready handshakes; the collecting counterpart of the team's 1-to-4 demux4 fan-out.
- Merges four WIDTH-bit source channels into one registered output stream.
- Tags each output word with its source channel index, so a downstream demux4 can route it back out.
- Sits between four producers and a single consumer (shared bus or link).

Parameters:
- WIDTH, 4, data width of every channel and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  channel 0 data.
- in1  input  WIDTH  channel 1 data.
- in2  input  WIDTH  channel 2 data.
- in3  input  WIDTH  channel 3 data.
- in_valid  input  4  per-channel valid; bit i belongs to in{i}.
- in_ready  output  4  per-channel accept; bit i belongs to in{i}.
- out  output  WIDTH  registered output data.
- out_sel  output  2  registered source index of out.
- out_valid  output  1  out/out_sel hold a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, out_sel=0, out_valid=0, priority pointer ptr=0.
- load = !out_valid || out_ready. Output register is free, or is emptying this cycle.
- Grant (combinational):
  - Search in_valid starting at ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
  - The first set bit wins; call it k.
  - At most one grant bit is set.
  - No valid request means no grant.
- in_ready[i] = load && grant[i]. At most one in_ready bit is high per cycle.
- in_ready may depend combinationally on in_valid and out_ready. This path is accepted.
- Transfer from channel k occurs when in_valid[k] && in_ready[k]. On that clock edge:
  - out <= in_k
  - out_sel <= k
  - out_valid <= 1
  - ptr <= (k+1) mod 4
- load with no valid request: out_valid <= 0. out, out_sel and ptr hold.
- !load (out_valid && !out_ready): out, out_sel, out_valid and ptr hold; all in_ready are 0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Fairness: with all four channels continuously valid, grants rotate 0,1,2,3,0,... Any requester waits at most 3 grants.
- Pointer moves only on a transfer. An idle cycle does not rotate priority.
- Simultaneous out_ready and new transfer: the old word is consumed and the new word is loaded on the same edge (no bubble).
- Source rules:
  - A source must hold in_valid and data stable until its in_ready.
  - A source may not withdraw in_valid before acceptance.
  - The block does not check these rules.
- Consumer rule: out and out_sel stay stable while out_valid && !out_ready.
- Reset mid-operation: any held output word is discarded and ptr returns to 0. Sources that were not accepted keep requesting and are served after reset release.
- A WIDTH change affects only the data paths. out_sel is always 2 bits.

Decomposition:
- Shared package rr_mux_pkg holds:
  - constant NUM_CH=4
  - constant SEL_W=2
  - typedef ch_sel_t (2-bit channel index), shared with the demux4 side for out_sel routing.
- One sub-module, rr_arb4:
  - Owns ptr and the rotating-priority grant logic.
  - Inputs: clk, rst_n, req[3:0], advance, adv_idx.
  - Output: one-hot grant[3:0].
  - The top level owns the output register, the data mux and the handshake.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out=0, out_sel=0, out_valid=0 immediately. After release, the first grant goes to the lowest-index valid channel (ptr=0).
- Single channel: in_valid=4'b0100, in2=4'hA, out_ready=1 -> next cycle out=4'hA, out_sel=2, out_valid=1. ptr becomes 3.
- Full contention: in_valid=4'b1111 held, data in0..in3 = 1,2,3,4, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out=1,2,3,4,1, no bubbles.
- Backpressure: out_ready=0 with out_valid=1 and in_valid=4'b0011 -> in_ready=0; out/out_sel unchanged for 5 cycles. Raising out_ready loads the granted channel on the same edge.
- Pointer hold on idle: grant ch1, then in_valid=0 for 3 cycles (out_valid drops to 0), then in_valid=4'b1001 -> ch3 granted before ch0 (ptr stayed at 2).
- Demux loopback: feed out/out_sel into demux4 out/s. Random stimulus on all four channels -> every word reappears on the output port matching its source index, in per-channel order, with none lost or duplicated.
